run_controller: RTL and testbench

- Synthesisable run-control and end-of-test monitor between the bench clock/reset source and `top`.
- Sequences core reset release over a parametrised hold period.
- Counts run cycles and watches the memory bus for a tohost write, reporting pass, fail code or timeout.
- Replaces fixed-delay `$finish` and ad-hoc reset flops with deterministic done/pass/fail outputs that the bench polls.

---
 rtl/run_controller.sv | 151 +++++++++++++++
 tb/tb_run_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run control and end-of-test monitor: sequences core reset, counts run cycles, detects the tohost write.
// Latency: every output is registered, so each reacts one posedge after the input that caused it; reset_n clears them at once.
// Backpressure: none; mem_* is observed passively every cycle and soft_reset may restart the sequence in any state.
//
// Ports:
//   clk, reset_n            clock and asynchronous active-low reset
//   soft_reset              synchronous restart of the reset sequence
//   mem_valid/addr/data     write bus from the core, watched for the tohost write
//   core_reset_n, running   registered reset to the core and the RUN indicator
//   done, pass, fail_code   tohost result (fail_code = data >> 1 when data != 1)
//   timeout, cycle_count    run budget exhausted, and RUN posedges elapsed
module run_controller #(
    parameter int unsigned          ADDR_W          = 32,
    parameter int unsigned          DATA_W          = 32,
    parameter int unsigned          CNT_W           = 32,
    parameter int unsigned          RST_HOLD_CYCLES = 4,
    parameter int unsigned          TIMEOUT_CYCLES  = 4800,
    parameter logic [ADDR_W-1:0]    TOHOST_ADDR     = 32'h0000_1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                soft_reset,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                core_reset_n,
    output logic                running,
    output logic                done,
    output logic                pass,
    output logic [DATA_W-1:0]   fail_code,
    output logic                timeout,
    output logic [CNT_W-1:0]    cycle_count
);

    // The hold counter only needs to reach RST_HOLD_CYCLES-1.
    localparam int unsigned     HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                core_reset_n_d;
    logic                running_d;
    logic                done_d;
    logic                pass_d;
    logic [DATA_W-1:0]   fail_code_d;
    logic                timeout_d;
    logic [CNT_W-1:0]    cycle_count_d;
    logic                tohost_hit;

    // Zero-data writes to tohost are not an end-of-test indication.
    assign tohost_hit = mem_valid && (mem_addr == TOHOST_ADDR) && (mem_data != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            core_reset_n <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_code    <= '0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            core_reset_n <= core_reset_n_d;
            running      <= running_d;
            done         <= done_d;
            pass         <= pass_d;
            fail_code    <= fail_code_d;
            timeout      <= timeout_d;
            cycle_count  <= cycle_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        core_reset_n_d = core_reset_n;
        running_d      = running;
        done_d         = done;
        pass_d         = pass;
        fail_code_d    = fail_code;
        timeout_d      = timeout;
        cycle_count_d  = cycle_count;

        if (soft_reset) begin
            // Restart overrides anything the current state would do this edge.
            state_d        = ST_HOLD;
            hold_cnt_d     = '0;
            core_reset_n_d = 1'b0;
            running_d      = 1'b0;
            done_d         = 1'b0;
            pass_d         = 1'b0;
            fail_code_d    = '0;
            timeout_d      = 1'b0;
            cycle_count_d  = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d        = ST_RUN;
                        hold_cnt_d     = '0;
                        core_reset_n_d = 1'b1;
                        running_d      = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    // The terminating edge is counted as a run cycle too.
                    cycle_count_d = cycle_count + CNT_W'(1);
                    if (tohost_hit) begin
                        state_d        = ST_DONE;
                        core_reset_n_d = 1'b0;
                        running_d      = 1'b0;
                        done_d         = 1'b1;
                        if (mem_data == DATA_W'(1)) begin
                            pass_d      = 1'b1;
                            fail_code_d = '0;
                        end else begin
                            pass_d      = 1'b0;
                            fail_code_d = mem_data >> 1;
                        end
                    end else if (cycle_count == CNT_LAST) begin
                        state_d        = ST_TIMEOUT;
                        core_reset_n_d = 1'b0;
                        running_d      = 1'b0;
                        timeout_d      = 1'b1;
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                    // Terminal: results are frozen until a reset of either kind.
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;

    localparam int unsigned HOLD   = 4;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        soft_reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    // Index 0: default parameters; index 1: TIMEOUT_CYCLES=16.
    logic        core_rn [2];
    logic        run_o   [2];
    logic        done_o  [2];
    logic        pass_o  [2];
    logic [31:0] fail_o  [2];
    logic        to_o    [2];
    logic [31:0] cyc_o   [2];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    run_controller dut_def (
        .clk(clk), .reset_n(reset_n), .soft_reset(soft_reset),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .core_reset_n(core_rn[0]), .running(run_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .fail_code(fail_o[0]), .timeout(to_o[0]),
        .cycle_count(cyc_o[0])
    );

    run_controller #(.TIMEOUT_CYCLES(16)) dut_t16 (
        .clk(clk), .reset_n(reset_n), .soft_reset(soft_reset),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .core_reset_n(core_rn[1]), .running(run_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .fail_code(fail_o[1]), .timeout(to_o[1]),
        .cycle_count(cyc_o[1])
    );

    // Reference model: edges left before the core is released, plus the observable results.
    int unsigned limit [2] = '{4800, 16};
    int unsigned m_hold_left [2];
    bit [31:0]   m_core [2];
    bit [31:0]   m_run  [2];
    bit [31:0]   m_done [2];
    bit [31:0]   m_pass [2];
    bit [31:0]   m_fail [2];
    bit [31:0]   m_to   [2];
    bit [31:0]   m_cyc  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hold_left[i] = HOLD;
            m_core[i] = 0; m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0;
            m_fail[i] = 0; m_to[i] = 0; m_cyc[i] = 0;
        end
    endtask

    // Advance the model by one posedge using the inputs currently applied.
    task automatic model_edge();
        bit hit;
        hit = mem_valid && (mem_addr == TOHOST) && (mem_data != 0);
        for (int i = 0; i < 2; i++) begin
            if (soft_reset) begin
                m_hold_left[i] = HOLD;
                m_core[i] = 0; m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0;
                m_fail[i] = 0; m_to[i] = 0; m_cyc[i] = 0;
            end else if (m_hold_left[i] > 0) begin
                m_hold_left[i]--;
                if (m_hold_left[i] == 0) begin
                    m_core[i] = 1;
                    m_run[i]  = 1;
                end
            end else if (m_run[i] == 1) begin
                m_cyc[i]++;
                if (hit) begin
                    m_done[i] = 1;
                    m_pass[i] = (mem_data == 1) ? 1 : 0;
                    m_fail[i] = (mem_data == 1) ? 0 : mem_data / 2;
                    m_core[i] = 0;
                    m_run[i]  = 0;
                end else if (m_cyc[i] == limit[i]) begin
                    m_to[i]   = 1;
                    m_core[i] = 0;
                    m_run[i]  = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d core_reset_n", i), 32'(core_rn[i]), m_core[i]);
            check($sformatf("d%0d running", i),      32'(run_o[i]),   m_run[i]);
            check($sformatf("d%0d done", i),         32'(done_o[i]),  m_done[i]);
            check($sformatf("d%0d pass", i),         32'(pass_o[i]),  m_pass[i]);
            check($sformatf("d%0d fail_code", i),    fail_o[i],       m_fail[i]);
            check($sformatf("d%0d timeout", i),      32'(to_o[i]),    m_to[i]);
            check($sformatf("d%0d cycle_count", i),  cyc_o[i],        m_cyc[i]);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic s);
        mem_valid  = v;
        mem_addr   = a;
        mem_data   = d;
        soft_reset = s;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < n; k++) step();
    endtask

    // Soft reset pulse followed by the hold period, ending on the release edge.
    task automatic restart();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        idle(HOLD);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        model_reset();
        #22;
        compare_all();

        // Reset release and hold period.
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold core_reset_n", 32'(core_rn[0]), 32'd0);
        end
        step();
        check("release core_reset_n", 32'(core_rn[0]), 32'd1);
        check("release running", 32'(run_o[0]), 32'd1);
        check("release cycle_count", cyc_o[0], 32'd0);

        // Pass on the 10th RUN posedge, later writes ignored.
        idle(9);
        drive(1'b1, TOHOST, 32'd1, 1'b0);
        step();
        check("pass done", 32'(done_o[0]), 32'd1);
        check("pass pass", 32'(pass_o[0]), 32'd1);
        check("pass cycle_count", cyc_o[0], 32'd10);
        check("pass core frozen", 32'(core_rn[0]), 32'd0);
        drive(1'b1, TOHOST, 32'd7, 1'b0);
        step();
        check("late write fail_code", fail_o[0], 32'd0);
        check("late write cycle_count", cyc_o[0], 32'd10);

        // Soft reset in DONE clears results.
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        check("soft in done done", 32'(done_o[0]), 32'd0);
        check("soft in done pass", 32'(pass_o[0]), 32'd0);
        idle(HOLD);
        check("soft release core", 32'(core_rn[0]), 32'd1);

        // Ignored writes, then a failing tohost value.
        drive(1'b1, 32'h0000_1004, 32'd7, 1'b0);
        step();
        drive(1'b1, TOHOST, 32'd0, 1'b0);
        step();
        check("ignored writes done", 32'(done_o[0]), 32'd0);
        drive(1'b1, TOHOST, 32'd7, 1'b0);
        step();
        check("fail done", 32'(done_o[0]), 32'd1);
        check("fail pass", 32'(pass_o[0]), 32'd0);
        check("fail fail_code", fail_o[0], 32'd3);

        // Timeout on the 16-cycle instance.
        restart();
        idle(15);
        check("pre timeout", 32'(to_o[1]), 32'd0);
        idle(1);
        check("timeout flag", 32'(to_o[1]), 32'd1);
        check("timeout cycle_count", cyc_o[1], 32'd16);
        check("timeout done", 32'(done_o[1]), 32'd0);
        check("default still running", 32'(run_o[0]), 32'd1);

        // Tohost on the timeout edge wins.
        restart();
        idle(15);
        drive(1'b1, TOHOST, 32'd1, 1'b0);
        step();
        check("tie done", 32'(done_o[1]), 32'd1);
        check("tie pass", 32'(pass_o[1]), 32'd1);
        check("tie timeout", 32'(to_o[1]), 32'd0);

        // Soft reset at RUN cycle 5.
        restart();
        idle(4);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        check("soft mid-run cycle_count", cyc_o[0], 32'd0);
        check("soft mid-run core", 32'(core_rn[0]), 32'd0);
        idle(3);
        check("soft hold core", 32'(core_rn[0]), 32'd0);
        idle(1);
        check("soft rerelease core", 32'(core_rn[0]), 32'd1);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            logic        v;
            logic [31:0] a, d;
            int          ra, rd;
            v  = ($urandom_range(0, 7) == 0);
            ra = $urandom_range(0, 3);
            rd = $urandom_range(0, 9);
            a  = (ra < 2) ? TOHOST : (ra == 2) ? 32'h0000_1004 : $urandom;
            d  = (rd == 0) ? 32'd0 : (rd == 1) ? 32'd1 : $urandom;
            drive(v, a, d, $urandom_range(0, 99) == 0);
            step();
        end

        // Asynchronous reset between edges in RUN.
        restart();
        idle(6);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async core_reset_n", 32'(core_rn[0]), 32'd0);
        check("async running", 32'(run_o[0]), 32'd0);
        check("async cycle_count", cyc_o[0], 32'd0);
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
        idle(HOLD + 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
